garduino_curtain_ctrl: RTL and testbench
========================================

GARDUINO_CURTAIN_CTRL -- requirements
Module: garduino_curtain_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3: number of curtain channels, legal range 1..8.
REQ-002 Parameter TIMER_W, default 16: width of the per-channel run timer, in ticks.
REQ-003 Parameter PRESCALE, default 50000: clk cycles per tick, minimum 2.
REQ-004 Parameter DEADTIME, default 100: ticks with both drives off before a direction reversal, minimum 1.
REQ-005 clk  in  1  system clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 address  in  3  Avalon-MM word address.
REQ-008 chipselect  in  1  slave select.
REQ-009 write_n  in  1  active-low write strobe.
REQ-010 writedata  in  32  write data.
REQ-011 readdata  out  32  read data, combinational from address, zero wait states.
REQ-012 limit_open  in  NUM_CH  per-channel fully-open switch, asynchronous, active-high.
REQ-013 limit_closed  in  NUM_CH  per-channel fully-closed switch, asynchronous, active-high.
REQ-014 motor_open  out  NUM_CH  per-channel open drive.
REQ-015 motor_close  out  NUM_CH  per-channel close drive.
REQ-016 irq  out  1  level interrupt; present only under CURTAIN_IRQ_EN.

Function
REQ-017 The register map SHALL be: addr 0 DURATION (R/W, TIMER_W bits); addr 1 CMD (write-only, reads 0): [NUM_CH-1:0] channel mask, [17:16] op (01 open, 10 close, 11 stop, 00 no-op); addr 2 STATUS (RO): [7:0] busy, [15:8] direction (1=close), [23:16] sync limit_open, [31:24] sync limit_closed; addr 3 DONE (sticky, write-1-to-clear); addr 4 IRQ_MASK (R/W). Unmapped addresses SHALL read 0 and ignore writes.
REQ-018 A write SHALL occur when chipselect=1 and write_n=0.
REQ-019 limit_open and limit_closed SHALL each pass through a 2-flop synchroniser before use.
REQ-020 A free-running prescaler SHALL emit a one-clk tick every PRESCALE cycles.
REQ-021 Each channel SHALL implement the states IDLE, DEAD, RUN_OPEN and RUN_CLOSE.
REQ-022 motor_open SHALL be 1 only in RUN_OPEN; motor_close SHALL be 1 only in RUN_CLOSE; both drives of a channel SHALL never be 1 together.
REQ-023 An open or close command to an IDLE channel SHALL load DURATION into its timer and enter the RUN state on the next clk.
REQ-024 A command in the same direction as the current RUN state SHALL reload the timer with DURATION and stay in RUN.
REQ-025 A command in the opposite direction of the current RUN state SHALL go to DEAD; after DEADTIME ticks the channel SHALL enter the new RUN state with the timer reloaded from DURATION.
REQ-026 A command received in DEAD SHALL replace the pending direction without restarting the dead time.
REQ-027 A stop command SHALL force IDLE on the next clk with drives off, and SHALL NOT set DONE.
REQ-028 In RUN, the timer SHALL decrement on each tick; at 0 the channel SHALL go to IDLE and set DONE[ch].
REQ-029 In RUN_OPEN, a synchronised limit_open SHALL end the run in the same way; in RUN_CLOSE, limit_closed SHALL do so; the limit check SHALL take priority over the tick.
REQ-030 A command with DURATION=0, or a command toward a limit that is already active, SHALL cause no drive and SHALL set DONE[ch] on the next clk.
REQ-031 If a DONE set and a W1C of the same bit occur in the same cycle, the set SHALL win.
REQ-032 busy[ch] SHALL be 1 in DEAD, RUN_OPEN and RUN_CLOSE.

Reset
REQ-033 While reset_n=0: all channels SHALL be IDLE; motor_open, motor_close, DONE, IRQ_MASK, the timers and the prescaler SHALL be 0; DURATION SHALL be 0; irq SHALL be 0.
REQ-034 Reset asserted mid-run SHALL drop all drives asynchronously, with no dead-time requirement on release.

Configuration
REQ-035 With CURTAIN_IRQ_EN defined, irq SHALL equal |(DONE & IRQ_MASK), registered.
REQ-036 Without CURTAIN_IRQ_EN, the irq port and the IRQ_MASK register SHALL be absent, and addr 4 SHALL read 0.

Verification
REQ-037 Bench settings PRESCALE=4, DEADTIME=2. Stimulus: DURATION=5, CMD mask=001 op=open. Required: motor_open[0]=1 for 5 ticks, then 0; DONE=001; STATUS busy=0.
REQ-038 Stimulus: ch1 running open with 10 ticks left, then CMD op=close. Required: both drives of ch1 are 0 for exactly 2 ticks, then motor_close[1]=1 for 5 ticks.
REQ-039 Stimulus: ch2 running close, then limit_closed[2] asserted. Required: motor_close[2]=0 within 3 clk of the input edge; DONE[2]=1.
REQ-040 Stimulus: CMD op=stop during a run; separately, DURATION=0 with op=open. Required: stop gives drives off and DONE unchanged; DURATION=0 gives no drive and DONE set next clk.
REQ-041 Stimulus: W1C of DONE[0] issued in the same cycle its timer expires. Required: DONE[0] remains 1.
REQ-042 Stimulus: CURTAIN_IRQ_EN defined, IRQ_MASK=010, ch1 completes. Required: irq=1; after W1C DONE=010, irq=0. Stimulus: reset_n pulsed mid-run. Required: all outputs 0.

Source files
------------

// File: rtl/garduino_curtain_ctrl_if.sv
// Avalon-MM slave bus bundle for the curtain controller.
interface garduino_curtain_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/garduino_curtain_ctrl.sv
// Multi-channel curtain motor controller with dead-time reversal, timed runs and limit stops.
// Define CURTAIN_IRQ_EN to add the IRQ_MASK register (addr 4) and the registered irq output.
module garduino_curtain_ctrl #(
  parameter int NUM_CH   = 3,
  parameter int TIMER_W  = 16,
  parameter int PRESCALE = 50000,
  parameter int DEADTIME = 100
) (
  input  logic                   clk,
  input  logic                   reset_n,
  garduino_curtain_ctrl_if.slave bus,
  input  logic [NUM_CH-1:0]      limit_open,
  input  logic [NUM_CH-1:0]      limit_closed,
  output logic [NUM_CH-1:0]      motor_open,
  output logic [NUM_CH-1:0]      motor_close
`ifdef CURTAIN_IRQ_EN
  ,
  output logic                   irq
`endif
);
  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [1:0] OP_OPEN  = 2'b01;
  localparam logic [1:0] OP_CLOSE = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [1:0] {IDLE, DEAD, RUN_OPEN, RUN_CLOSE} ch_state_t;

  logic [NUM_CH-1:0]  lo_meta_reg, lo_sync_reg, lc_meta_reg, lc_sync_reg;
  logic [PW-1:0]      pre_cnt_reg;
  logic [TIMER_W-1:0] duration_reg;
  logic [NUM_CH-1:0]  done, busy, dir_close;
  logic [31:0]        status;
  logic               tick, wr, cmd_wr, done_wr;
  logic [1:0]         op;
  logic               unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign cmd_wr       = wr && (bus.address == 3'd1);
  assign done_wr      = wr && (bus.address == 3'd3);
  assign op           = bus.writedata[17:16];
  assign tick         = (pre_cnt_reg == PW'(PRESCALE - 1));
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_meta_reg  <= '0;
      lo_sync_reg  <= '0;
      lc_meta_reg  <= '0;
      lc_sync_reg  <= '0;
      pre_cnt_reg  <= '0;
      duration_reg <= '0;
    end else begin
      lo_meta_reg <= limit_open;
      lo_sync_reg <= lo_meta_reg;
      lc_meta_reg <= limit_closed;
      lc_sync_reg <= lc_meta_reg;
      pre_cnt_reg <= tick ? '0 : pre_cnt_reg + PW'(1);
      if (wr && bus.address == 3'd0)
        duration_reg <= bus.writedata[TIMER_W-1:0];
    end
  end

`ifdef CURTAIN_IRQ_EN
  logic [NUM_CH-1:0] irq_mask_reg;
  logic              irq_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      if (wr && bus.address == 3'd4)
        irq_mask_reg <= bus.writedata[NUM_CH-1:0];
      irq_reg <= |(done & irq_mask_reg);
    end
  end
  assign irq = irq_reg;
`endif

  always_comb begin
    status                 = '0;
    status[NUM_CH-1:0]     = busy;
    status[8 +: NUM_CH]    = dir_close;
    status[16 +: NUM_CH]   = lo_sync_reg;
    status[24 +: NUM_CH]   = lc_sync_reg;
    bus.readdata = '0;
    case (bus.address)
      3'd0: bus.readdata[TIMER_W-1:0] = duration_reg;
      3'd2: bus.readdata = status;
      3'd3: bus.readdata[NUM_CH-1:0] = done;
`ifdef CURTAIN_IRQ_EN
      3'd4: bus.readdata[NUM_CH-1:0] = irq_mask_reg;
`endif
      default: bus.readdata = '0;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_t          state_reg;
    logic [TIMER_W-1:0] timer_reg;
    logic [DW-1:0]      dead_reg;
    logic               pend_close_reg, open_reg, close_reg, done_reg;
    logic               hit, want_close, blocked;

    assign hit        = cmd_wr & bus.writedata[gi];
    assign want_close = (op == OP_CLOSE);
    // Zero duration or a target limit already reached completes without driving.
    assign blocked    = (duration_reg == '0) ||
                        (want_close ? lc_sync_reg[gi] : lo_sync_reg[gi]);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg      <= IDLE;
        timer_reg      <= '0;
        dead_reg       <= '0;
        pend_close_reg <= 1'b0;
        open_reg       <= 1'b0;
        close_reg      <= 1'b0;
        done_reg       <= 1'b0;
      end else begin
        // A completion later in this block overrides the clear.
        if (done_wr && bus.writedata[gi])
          done_reg <= 1'b0;
        if (hit && op == OP_STOP) begin
          state_reg <= IDLE;
          open_reg  <= 1'b0;
          close_reg <= 1'b0;
        end else if (hit && (op == OP_OPEN || op == OP_CLOSE)) begin
          pend_close_reg <= want_close;
          if (blocked) begin
            state_reg <= IDLE;
            open_reg  <= 1'b0;
            close_reg <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            case (state_reg)
              IDLE: begin
                state_reg <= want_close ? RUN_CLOSE : RUN_OPEN;
                timer_reg <= duration_reg;
                open_reg  <= ~want_close;
                close_reg <= want_close;
              end
              RUN_OPEN, RUN_CLOSE: begin
                if (want_close == (state_reg == RUN_CLOSE)) begin
                  timer_reg <= duration_reg;
                end else begin
                  state_reg <= DEAD;
                  dead_reg  <= DW'(DEADTIME);
                  open_reg  <= 1'b0;
                  close_reg <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end else begin
          case (state_reg)
            RUN_OPEN, RUN_CLOSE: begin
              if ((state_reg == RUN_OPEN && lo_sync_reg[gi]) ||
                  (state_reg == RUN_CLOSE && lc_sync_reg[gi]) ||
                  (tick && timer_reg <= TIMER_W'(1))) begin
                state_reg <= IDLE;
                open_reg  <= 1'b0;
                close_reg <= 1'b0;
                done_reg  <= 1'b1;
              end else if (tick) begin
                timer_reg <= timer_reg - TIMER_W'(1);
              end
            end
            DEAD: begin
              if (tick) begin
                if (dead_reg <= DW'(1)) begin
                  state_reg <= pend_close_reg ? RUN_CLOSE : RUN_OPEN;
                  timer_reg <= duration_reg;
                  open_reg  <= ~pend_close_reg;
                  close_reg <= pend_close_reg;
                end else begin
                  dead_reg <= dead_reg - DW'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign motor_open[gi]  = open_reg;
    assign motor_close[gi] = close_reg;
    assign busy[gi]        = (state_reg != IDLE);
    assign dir_close[gi]   = pend_close_reg;
    assign done[gi]        = done_reg;
  end
endmodule

// File: tb/tb_garduino_curtain_ctrl.sv
// Scenario bench for garduino_curtain_ctrl; expectations queued per stimulus, popped at observation.
`timescale 1ns/1ps
module tb_garduino_curtain_ctrl;
  localparam int NUM_CH = 3, TIMER_W = 16, PRESCALE = 4, DEADTIME = 2;
  localparam logic [31:0] OPEN = 32'h0001_0000, CLOSE = 32'h0002_0000, STOP = 32'h0003_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NUM_CH-1:0] limit_open = '0, limit_closed = '0, motor_open, motor_close;
`ifdef CURTAIN_IRQ_EN
  logic irq;
`endif

  garduino_curtain_ctrl_if bif();

  garduino_curtain_ctrl #(.NUM_CH(NUM_CH), .TIMER_W(TIMER_W), .PRESCALE(PRESCALE), .DEADTIME(DEADTIME)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bif),
    .limit_open(limit_open),
    .limit_closed(limit_closed),
    .motor_open(motor_open),
    .motor_close(motor_close)
`ifdef CURTAIN_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] obs;
  int          total = 0, bad = 0, cyc = 0, overlap = 0, n = 0, phase = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (|(motor_open & motor_close)) overlap++;

  task automatic push(input string nm, input logic [31:0] v);
    exp_t t;
    t.name = nm;
    t.val  = v;
    exp_q.push_back(t);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bif.address = a; bif.writedata = d; bif.chipselect = 1'b1; bif.write_n = 1'b0;
    @(negedge clk);
    bif.chipselect = 1'b0; bif.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bif.address = a;
    #1 d = bif.readdata;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    push("reset_motors", 0);
    obs = 32'({motor_close, motor_open});
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    for (int a = 0; a < 6; a++) begin
      push($sformatf("reset_read_addr%0d", a), 0);
      bus_read(3'(a), obs);
      e = exp_q.pop_front(); total++;
      if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'h0000_0007);
    push("unmapped_read", 0);
    bus_read(3'd5, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("cmd_reads_zero", 0);
    bus_read(3'd1, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
  endtask

  task automatic test_open_run();
    bus_write(3'd0, 32'd5);
    push("open_dur_readback", 5);
    bus_read(3'd0, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("open_start", 1);
    bus_write(3'd1, OPEN | 32'h1);
    obs = 32'(motor_open[0]);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("open_ticks", 5);
    n = 0;
    while (motor_open[0] === 1'b1 && n < 200) begin @(negedge clk); n++; end
    obs = 32'((n + PRESCALE - 1) / PRESCALE);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, obs, e.val); end
    push("open_done", 32'h1);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("open_busy", 0);
    bus_read(3'd2, obs);
    obs = obs & 32'hFF;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd3, 32'h1);
    push("open_w1c", 0);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
  endtask

  task automatic test_reverse();
    bus_write(3'd0, 32'd10);
    bus_write(3'd1, OPEN | 32'h2);
    repeat (3) @(negedge clk);
    bus_write(3'd0, 32'd5);
    push("rev_drives_off", 0);
    bus_write(3'd1, CLOSE | 32'h2);
    obs = 32'({motor_open[1], motor_close[1]});
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("rev_status_busy_dir", 32'h0202);
    bus_read(3'd2, obs);
    obs = obs & 32'hFFFF;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("rev_dead_ticks", 2);
    n = 0;
    while (motor_open[1] === 1'b0 && motor_close[1] === 1'b0 && n < 200) begin @(negedge clk); n++; end
    obs = 32'((n + PRESCALE - 1) / PRESCALE);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, obs, e.val); end
    push("rev_close_ticks", 5);
    n = 0;
    while (motor_close[1] === 1'b1 && n < 200) begin @(negedge clk); n++; end
    obs = 32'((n + PRESCALE - 1) / PRESCALE);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, obs, e.val); end
    push("rev_done", 32'h2);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd3, 32'h2);
  endtask

  task automatic test_limit();
    bus_write(3'd0, 32'd50);
    bus_write(3'd1, CLOSE | 32'h4);
    repeat (4) @(negedge clk);
    push("lim_running", 1);
    obs = 32'(motor_close[2]);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    limit_closed[2] = 1'b1;
    push("lim_stop_within_3clk", 1);
    n = 0;
    while (motor_close[2] === 1'b1 && n < 20) begin @(negedge clk); n++; end
    obs = 32'(n <= 3);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %0d (after %0d clk) want %0d", e.name, obs, n, e.val); end
    push("lim_done", 32'h4);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd3, 32'h4);
    push("lim_status_sync", 32'h0400_0000);
    bus_read(3'd2, obs);
    obs = obs & 32'hFFFF_0000;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("lim_blocked_drive", 0);
    bus_write(3'd1, CLOSE | 32'h4);
    obs = 32'(motor_close[2]);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("lim_blocked_done", 32'h4);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    limit_closed[2] = 1'b0;
    bus_write(3'd3, 32'h4);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stop_zero();
    bus_write(3'd0, 32'd20);
    bus_write(3'd1, OPEN | 32'h1);
    repeat (3) @(negedge clk);
    push("stop_drive_off", 0);
    bus_write(3'd1, STOP | 32'h1);
    obs = 32'(motor_open[0]);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("stop_done_unchanged", 0);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("stop_busy", 0);
    bus_read(3'd2, obs);
    obs = obs & 32'hFF;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd0, 32'd0);
    push("zero_dur_no_drive", 0);
    bus_write(3'd1, OPEN | 32'h1);
    obs = 32'({motor_open[0], motor_close[0]});
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("zero_dur_done", 32'h1);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd3, 32'h1);
  endtask

  task automatic test_w1c_race();
    bus_write(3'd0, 32'd1);
    bus_write(3'd1, OPEN | 32'h1);
    n = 0;
    while (motor_open[0] === 1'b1 && n < 50) begin @(negedge clk); n++; end
    phase = cyc % PRESCALE;
    push("race_probe_done", 32'h1);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd3, 32'h1);
    bus_write(3'd1, OPEN | 32'h1);
    n = 0;
    while (((cyc + 1) % PRESCALE) != phase && n < 10) begin @(negedge clk); n++; end
    push("race_run_expired", 0);
    bus_write(3'd3, 32'h1);
    obs = 32'(motor_open[0]);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("race_done_kept", 32'h1);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd3, 32'h1);
    push("race_cleared", 0);
    bus_read(3'd3, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
  endtask

  task automatic test_irq();
`ifdef CURTAIN_IRQ_EN
    bus_write(3'd4, 32'h2);
    push("irq_mask_readback", 32'h2);
    bus_read(3'd4, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("irq_idle", 0);
    obs = 32'(irq);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd0, 32'd2);
    bus_write(3'd1, OPEN | 32'h2);
    n = 0;
    while (motor_open[1] === 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    push("irq_set", 1);
    obs = 32'(irq);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd3, 32'h2);
    @(negedge clk);
    push("irq_cleared", 0);
    obs = 32'(irq);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    bus_write(3'd4, 32'h0);
`else
    bus_write(3'd4, 32'h2);
    push("irq_mask_absent", 0);
    bus_read(3'd4, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
`endif
  endtask

  task automatic test_reset_midrun();
    bus_write(3'd0, 32'd50);
    bus_write(3'd1, OPEN | 32'h1);
    bus_write(3'd1, CLOSE | 32'h2);
    repeat (2) @(negedge clk);
    push("midrun_running", 32'b010_001);
    obs = 32'({motor_close, motor_open});
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    #2 reset_n = 1'b0;
    #1;
    push("midrun_async_off", 0);
    obs = 32'({motor_close, motor_open});
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    @(negedge clk);
    push("midrun_duration_cleared", 0);
    bus_read(3'd0, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("midrun_status_cleared", 0);
    bus_read(3'd2, obs);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    push("after_release_idle", 0);
    obs = 32'({motor_close, motor_open});
`ifdef CURTAIN_IRQ_EN
    obs = obs | 32'({irq, 8'h00});
`endif
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, obs, e.val); end
    push("drive_overlap_count", 0);
    obs = 32'(overlap);
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, obs, e.val); end
  endtask

  initial begin
    bif.address    = 3'd0;
    bif.chipselect = 1'b0;
    bif.write_n    = 1'b1;
    bif.writedata  = 32'h0;
    test_reset();
    test_open_run();
    test_reverse();
    test_limit();
    test_stop_zero();
    test_w1c_race();
    test_irq();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
